cycle_ctrl: RTL and testbench

CYCLE_CTRL -- requirements
Module: cycle_ctrl

---
 rtl/cycle_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_cycle_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_ctrl.sv
// cycle_ctrl: CPU bus-cycle controller. It decodes chip-select hits, runs the
// per-channel wait states, returns DSACK with the channel's port size, and
// raises a bus error on any unterminated cycle.
// Optional feature macro: CYCLE_CTRL_STERM_EN. When it is defined, port code 11
// gives a one-clock synchronous STERM pulse. When it is undefined, code 11 is
// treated as a 32-bit DSACK and nSterm is tied high.
module cycle_ctrl #(
  parameter int                         NUM_CS      = 4,
  parameter int                         WAIT_W      = 4,
  parameter logic [NUM_CS*WAIT_W-1:0]   CS_WAIT     = '0,
  parameter logic [NUM_CS*2-1:0]        CS_PORT     = '0,
  parameter int                         BERR_CYCLES = 64
) (
  input  logic              sysClk,
  input  logic              sysReset,
  input  logic              nAS,
  input  logic              nDS,
  input  logic              RnW,
  input  logic              addr31,
  input  logic [1:0]        cpuFC,
  input  logic [2:0]        addrSel,
  input  logic              nExtTerm,
  output logic [NUM_CS-1:0] nCS,
  output logic [1:0]        nDsack,
  output logic              nSterm,
  output logic              nBerr,
  output logic              nMemRd,
  output logic              nMemWr
);

  // The timeout counter must be able to hold BERR_CYCLES itself.
  localparam int               TO_W    = $clog2(BERR_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(BERR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    BERR,
    DONE
  } stateType;

  stateType              stateReg, stateNext;
  logic [2:0]            chSelReg, chSelNext;
  logic [WAIT_W-1:0]     waitCntReg, waitCntNext;
  logic [TO_W-1:0]       toCntReg, toCntNext;
  logic                  armedReg, armedNext;
  logic [NUM_CS-1:0]     nCsReg, nCsNext;
  logic [1:0]            nDsackReg, nDsackNext;
  logic                  nBerrReg, nBerrNext;

  // Per-channel tables. They are always eight deep so that addrSel indexes them
  // directly. Slots at or above NUM_CS are marked invalid and never selected.
  logic                  chValid [0:7];
  logic [WAIT_W-1:0]     chWait  [0:7];
  logic [1:0]            chDsack [0:7];
`ifdef CYCLE_CTRL_STERM_EN
  logic                  chSync  [0:7];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : gChan
      if (gi < NUM_CS) begin : gUsed
        localparam logic [1:0] PORT = CS_PORT[gi*2 +: 2];
        assign chValid[gi] = 1'b1;
        assign chWait[gi]  = CS_WAIT[gi*WAIT_W +: WAIT_W];
`ifdef CYCLE_CTRL_STERM_EN
        // Sync ports terminate with STERM. DSACK stays negated (11).
        assign chDsack[gi] = PORT;
        assign chSync[gi]  = (PORT == 2'b11);
`else
        // Without STERM support, a sync port falls back to 32-bit DSACK.
        assign chDsack[gi] = (PORT == 2'b11) ? 2'b00 : PORT;
`endif
      end else begin : gUnused
        assign chValid[gi] = 1'b0;
        assign chWait[gi]  = '0;
        assign chDsack[gi] = 2'b11;
`ifdef CYCLE_CTRL_STERM_EN
        assign chSync[gi]  = 1'b0;
`endif
      end
    end
  endgenerate

  logic hit;
  logic toCount;
  logic toExpire;

  assign hit = !nAS && addr31 && (cpuFC != 2'b11) && chValid[addrSel];

  // The timeout runs only while the cycle is still unterminated. ACK counts as
  // an internal termination. BERR has already terminated the cycle, and DONE
  // sees nAS high.
  assign toCount  = !nAS && nExtTerm && ((stateReg == IDLE) || (stateReg == WAIT));
  assign toExpire = toCount && (toCntReg >= TO_LAST);

  // Timeout counter. It clears whenever nAS is high and holds while a
  // termination is present.
  always_comb begin
    toCntNext = toCntReg;
    if (nAS) begin
      toCntNext = '0;
    end else if (toCount && (toCntReg < TO_W'(BERR_CYCLES))) begin
      toCntNext = toCntReg + TO_W'(1);
    end
  end

  // After reset, a cycle is only accepted once nAS has been seen high. This
  // prevents an interrupted cycle from restarting.
  assign armedNext = armedReg | nAS;

  // Next-state logic. In WAIT, an abort (nAS high) wins over everything else,
  // and reaching ACK wins over a timeout that expires on the same edge.
  always_comb begin
    stateNext   = stateReg;
    chSelNext   = chSelReg;
    waitCntNext = waitCntReg;
    case (stateReg)
      IDLE: begin
        if (toExpire) begin
          stateNext = BERR;
        end else if (hit && armedReg) begin
          stateNext   = WAIT;
          chSelNext   = addrSel;
          waitCntNext = chWait[addrSel];
        end
      end
      WAIT: begin
        if (nAS) begin
          stateNext = DONE;
        end else if (waitCntReg == '0) begin
          stateNext = ACK;
        end else if (toExpire) begin
          stateNext = BERR;
        end else begin
          waitCntNext = waitCntReg - WAIT_W'(1);
        end
      end
      ACK: begin
        if (nAS) stateNext = DONE;
      end
      BERR: begin
        if (nAS) stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the next state. This keeps the bus
  // strobes glitch-free and aligns them with the state change.
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : gCs
      assign nCsNext[gi] = !(((stateNext == WAIT) || (stateNext == ACK)) &&
                             (chSelNext == 3'(gi)));
    end
  endgenerate

  assign nDsackNext = (stateNext == ACK) ? chDsack[chSelNext] : 2'b11;
  assign nBerrNext  = (stateNext != BERR);

  // Control state registers. Reset abandons any cycle in progress.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      stateReg   <= IDLE;
      chSelReg   <= '0;
      waitCntReg <= '0;
      toCntReg   <= '0;
      armedReg   <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      chSelReg   <= chSelNext;
      waitCntReg <= waitCntNext;
      toCntReg   <= toCntNext;
      armedReg   <= armedNext;
    end
  end

  // Bus output registers. All of them are negated during reset.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      nCsReg    <= '1;
      nDsackReg <= 2'b11;
      nBerrReg  <= 1'b1;
    end else begin
      nCsReg    <= nCsNext;
      nDsackReg <= nDsackNext;
      nBerrReg  <= nBerrNext;
    end
  end

`ifdef CYCLE_CTRL_STERM_EN
  logic nStermReg, nStermNext;

  // STERM is a single-clock pulse on the edge that enters ACK on a sync port.
  assign nStermNext = !((stateReg == WAIT) && (stateNext == ACK) && chSync[chSelReg]);

  // STERM pulse register.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      nStermReg <= 1'b1;
    end else begin
      nStermReg <= nStermNext;
    end
  end

  assign nSterm = nStermReg;
`else
  assign nSterm = 1'b1;
`endif

  logic anyCs;
  assign anyCs  = ~&nCsReg;

  assign nCS    = nCsReg;
  assign nDsack = nDsackReg;
  assign nBerr  = nBerrReg;
  assign nMemRd = !(anyCs && RnW);
  assign nMemWr = !(anyCs && !RnW && !nDS);

endmodule

// File: tb/tb_cycle_ctrl.sv
// tb_cycle_ctrl: directed and randomized bus cycles for cycle_ctrl. Expected
// outputs come from a timeline model built on the cycle rules. The model gives
// the edge of nCS, the edge of ACK and the edge of the timeout.
module tb_cycle_ctrl;
  localparam int BERR = 16;

  logic       sysClk = 1'b0;
  logic       sysReset, nAS, nDS, RnW, addr31, nExtTerm;
  logic [1:0] cpuFC;
  logic [2:0] addrSel;
  logic [3:0] nCS;
  logic [1:0] nDsack;
  logic       nSterm, nBerr, nMemRd, nMemWr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] cs;
    logic [1:0] ds;
    logic       st;
    logic       be;
    logic       rd;
    logic       wr;
  } outs_t;

  localparam outs_t ALL_HIGH = '1;

  outs_t obsLog [0:127];
  logic  ndsLog [0:127];

  // Channel configuration as seen by the bench. Channel 3 has wait 14, so its
  // ACK falls exactly on the timeout edge.
  int         chWaitTb [4] = '{0, 1, 3, 14};
  logic [1:0] chPortTb [4] = '{2'b00, 2'b11, 2'b10, 2'b01};

`ifdef CYCLE_CTRL_STERM_EN
  localparam bit STERM_EN = 1'b1;
`else
  localparam bit STERM_EN = 1'b0;
`endif

  always #5 sysClk = ~sysClk;

  cycle_ctrl #(
    .NUM_CS(4),
    .WAIT_W(4),
    .CS_WAIT(16'hE310),
    .CS_PORT(8'b01_10_11_00),
    .BERR_CYCLES(BERR)
  ) dut (
    .sysClk(sysClk),
    .sysReset(sysReset),
    .nAS(nAS),
    .nDS(nDS),
    .RnW(RnW),
    .addr31(addr31),
    .cpuFC(cpuFC),
    .addrSel(addrSel),
    .nExtTerm(nExtTerm),
    .nCS(nCS),
    .nDsack(nDsack),
    .nSterm(nSterm),
    .nBerr(nBerr),
    .nMemRd(nMemRd),
    .nMemWr(nMemWr)
  );

  function automatic outs_t observe();
    return outs_t'({nCS, nDsack, nSterm, nBerr, nMemRd, nMemWr});
  endfunction

  function automatic bit is_hit(logic a31, logic [1:0] fc, int sel);
    return a31 && (fc != 2'b11) && (sel < 4);
  endfunction

  // Expected outputs after edge k of a cycle. nAS is sampled low on edges 1..len
  // and high on edge len+1. A hit is accepted on edge 'start'. ACK arrives
  // wait+1 edges after that. A timeout fires on edge BERR unless ACK has
  // already arrived or arrives on the same edge.
  function automatic outs_t model(int k, bit hit, int sel, bit rnw, bit nds,
                                  int len, int start, bit ext);
    outs_t      o;
    int         ackE;
    int         berrE;
    logic [1:0] code;
    o     = ALL_HIGH;
    ackE  = 1 << 30;
    berrE = 1 << 30;
    if (hit) begin
      ackE = start + chWaitTb[sel] + 1;
      if (ext && ackE > BERR && len >= BERR) berrE = BERR;
    end else if (ext && len >= BERR) begin
      berrE = BERR;
    end
    if (k >= berrE && k <= len) o.be = 1'b0;
    if (hit && k >= start && k <= len && k < berrE) begin
      o.cs[sel] = 1'b0;
      o.rd      = !rnw;
      o.wr      = !(!rnw && !nds);
      if (k >= ackE) begin
        code = chPortTb[sel];
        if (code == 2'b11) begin
          if (STERM_EN) begin
            o.ds = 2'b11;
            if (k == ackE) o.st = 1'b0;
          end else begin
            o.ds = 2'b00;
          end
        end else begin
          o.ds = code;
        end
      end
    end
    return o;
  endfunction

  // Drive one cycle with nAS low for len edges, then observe tail more edges.
  task automatic run_txn(input logic a31, input logic [1:0] fc, input int sel,
                         input logic rnw, input logic ext, input int len, input int tail);
    @(negedge sysClk);
    addr31   = a31;
    cpuFC    = fc;
    addrSel  = 3'(sel);
    RnW      = rnw;
    nExtTerm = ext;
    nAS      = 1'b0;
    nDS      = 1'($urandom_range(0, 1));
    for (int k = 1; k <= len + tail; k++) begin
      @(negedge sysClk);
      obsLog[k] = observe();
      ndsLog[k] = nDS;
      if (k == len) begin
        nAS = 1'b1;
        nDS = 1'b1;
      end else if (k < len) begin
        nDS = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset();
    sysReset = 1'b1; nAS = 1'b1; nDS = 1'b1; RnW = 1'b1; addr31 = 1'b0;
    cpuFC = 2'b00; addrSel = 3'd0; nExtTerm = 1'b1;
    #2;
    checks++;
    if (observe() !== ALL_HIGH) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", observe(), ALL_HIGH);
    end
    repeat (3) @(negedge sysClk);
    sysReset = 1'b0;
    repeat (2) @(negedge sysClk);
    checks++;
    if (observe() !== ALL_HIGH) begin
      errors++; $display("FAIL idle_after_reset: got %b want %b", observe(), ALL_HIGH);
    end
    $display("txn reset: outputs checked during and after reset");
  endtask

  task automatic test_read_wait();
    outs_t want;
    run_txn(1'b1, 2'b01, 2, 1'b1, 1'b1, 8, 2);
    for (int k = 1; k <= 10; k++) begin
      want = model(k, 1'b1, 2, 1'b1, ndsLog[k], 8, 1, 1'b1);
      checks++;
      if (obsLog[k] !== want) begin
        errors++; $display("FAIL read_wait edge %0d: got %b want %b", k, obsLog[k], want);
      end
    end
    checks++;
    if (obsLog[1].cs !== 4'b1011) begin
      errors++; $display("FAIL read_wait_cs: got %b want 1011", obsLog[1].cs);
    end
    checks++;
    if (obsLog[1].rd !== 1'b0) begin
      errors++; $display("FAIL read_wait_memrd: got %b want 0", obsLog[1].rd);
    end
    checks++;
    if (obsLog[4].ds !== 2'b11 || obsLog[5].ds !== 2'b10) begin
      errors++; $display("FAIL read_wait_dsack: got %b,%b want 11,10", obsLog[4].ds, obsLog[5].ds);
    end
    checks++;
    if (obsLog[9] !== ALL_HIGH) begin
      errors++; $display("FAIL read_wait_release: got %b want %b", obsLog[9], ALL_HIGH);
    end
    $display("txn read ch2 wait3: nCS edge1, nDsack edge5, release edge9");
  endtask

  task automatic test_write_zero_wait();
    outs_t want;
    run_txn(1'b1, 2'b01, 0, 1'b0, 1'b1, 6, 2);
    for (int k = 1; k <= 8; k++) begin
      want = model(k, 1'b1, 0, 1'b0, ndsLog[k], 6, 1, 1'b1);
      checks++;
      if (obsLog[k] !== want) begin
        errors++; $display("FAIL write_wait0 edge %0d: got %b want %b", k, obsLog[k], want);
      end
    end
    checks++;
    if (obsLog[1].cs !== 4'b1110 || obsLog[1].ds !== 2'b11 || obsLog[2].ds !== 2'b00) begin
      errors++; $display("FAIL write_wait0_timing: got cs=%b ds=%b,%b want 1110 11,00",
                         obsLog[1].cs, obsLog[1].ds, obsLog[2].ds);
    end
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (obsLog[k].wr !== ndsLog[k]) begin
        errors++; $display("FAIL write_memwr edge %0d: got %b want %b", k, obsLog[k].wr, ndsLog[k]);
      end
    end
    $display("txn write ch0 wait0: nDsack one clock after nCS");
  endtask

  task automatic test_unmapped_berr();
    outs_t want;
    run_txn(1'b1, 2'b01, 5, 1'b1, 1'b1, 20, 2);
    for (int k = 1; k <= 22; k++) begin
      want = model(k, 1'b0, 5, 1'b1, ndsLog[k], 20, 1, 1'b1);
      checks++;
      if (obsLog[k] !== want) begin
        errors++; $display("FAIL unmapped_berr edge %0d: got %b want %b", k, obsLog[k], want);
      end
    end
    checks++;
    if (obsLog[15].be !== 1'b1 || obsLog[16].be !== 1'b0 || obsLog[16].cs !== 4'hF
        || obsLog[21].be !== 1'b1) begin
      errors++; $display("FAIL unmapped_berr_timing: got be15=%b be16=%b cs16=%b be21=%b want 1 0 1111 1",
                         obsLog[15].be, obsLog[16].be, obsLog[16].cs, obsLog[21].be);
    end
    $display("txn unmapped sel5: nBerr at edge16, released edge21");
  endtask

  task automatic test_extterm_no_berr();
    outs_t want;
    run_txn(1'b0, 2'b01, 0, 1'b1, 1'b0, 100, 2);
    for (int k = 1; k <= 102; k++) begin
      want = model(k, 1'b0, 0, 1'b1, ndsLog[k], 100, 1, 1'b0);
      checks++;
      if (obsLog[k] !== want) begin
        errors++; $display("FAIL extterm_no_berr edge %0d: got %b want %b", k, obsLog[k], want);
      end
    end
    checks++;
    if (obsLog[100].be !== 1'b1) begin
      errors++; $display("FAIL extterm_berr100: got %b want 1", obsLog[100].be);
    end
    $display("txn addr31=0 nExtTerm=0 for 100 clocks: no nBerr");
  endtask

  task automatic test_sync_port();
    outs_t want;
    run_txn(1'b1, 2'b10, 1, 1'b1, 1'b1, 6, 2);
    for (int k = 1; k <= 8; k++) begin
      want = model(k, 1'b1, 1, 1'b1, ndsLog[k], 6, 1, 1'b1);
      checks++;
      if (obsLog[k] !== want) begin
        errors++; $display("FAIL sync_port edge %0d: got %b want %b", k, obsLog[k], want);
      end
    end
`ifdef CYCLE_CTRL_STERM_EN
    checks++;
    if (obsLog[3].st !== 1'b0 || obsLog[4].st !== 1'b1 || obsLog[3].ds !== 2'b11) begin
      errors++; $display("FAIL sterm_pulse: got st=%b,%b ds=%b want 0,1 11",
                         obsLog[3].st, obsLog[4].st, obsLog[3].ds);
    end
`else
    checks++;
    if (obsLog[3].ds !== 2'b00 || obsLog[3].st !== 1'b1) begin
      errors++; $display("FAIL sync_as_32bit: got ds=%b st=%b want 00 1", obsLog[3].ds, obsLog[3].st);
    end
`endif
    $display("txn ch1 sync port wait1: ack at edge3");
  endtask

  task automatic test_timeout_tie();
    outs_t want;
    run_txn(1'b1, 2'b01, 3, 1'b1, 1'b1, 20, 2);
    for (int k = 1; k <= 22; k++) begin
      want = model(k, 1'b1, 3, 1'b1, ndsLog[k], 20, 1, 1'b1);
      checks++;
      if (obsLog[k] !== want) begin
        errors++; $display("FAIL timeout_tie edge %0d: got %b want %b", k, obsLog[k], want);
      end
    end
    checks++;
    if (obsLog[15].ds !== 2'b11 || obsLog[16].ds !== 2'b01 || obsLog[16].be !== 1'b1) begin
      errors++; $display("FAIL tie_ack_wins: got ds=%b,%b be=%b want 11,01 1",
                         obsLog[15].ds, obsLog[16].ds, obsLog[16].be);
    end
    $display("txn ch3 wait14: ack and timeout on edge16, ack wins");
  endtask

  task automatic test_abort_wait();
    outs_t want;
    run_txn(1'b1, 2'b01, 2, 1'b0, 1'b1, 3, 2);
    for (int k = 1; k <= 5; k++) begin
      want = model(k, 1'b1, 2, 1'b0, ndsLog[k], 3, 1, 1'b1);
      checks++;
      if (obsLog[k] !== want) begin
        errors++; $display("FAIL abort_wait edge %0d: got %b want %b", k, obsLog[k], want);
      end
    end
    checks++;
    if (obsLog[3].cs !== 4'b1011 || obsLog[4].cs !== 4'hF || obsLog[4].ds !== 2'b11) begin
      errors++; $display("FAIL abort_release: got cs=%b,%b ds=%b want 1011,1111 11",
                         obsLog[3].cs, obsLog[4].cs, obsLog[4].ds);
    end
    $display("txn ch2 abort during wait: no nDsack");
  endtask

  task automatic test_reset_mid_wait();
    outs_t want;
    @(negedge sysClk);
    addr31 = 1'b1; cpuFC = 2'b01; addrSel = 3'd3; RnW = 1'b1; nExtTerm = 1'b1;
    nAS = 1'b0; nDS = 1'b0;
    repeat (3) @(negedge sysClk);
    checks++;
    if (nCS !== 4'b0111) begin
      errors++; $display("FAIL mid_wait_cs: got %b want 0111", nCS);
    end
    #2 sysReset = 1'b1;
    #1;
    checks++;
    if (observe() !== ALL_HIGH) begin
      errors++; $display("FAIL reset_async: got %b want %b", observe(), ALL_HIGH);
    end
    @(negedge sysClk);
    sysReset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge sysClk);
      checks++;
      if (observe() !== ALL_HIGH) begin
        errors++; $display("FAIL no_restart edge %0d: got %b want %b", k, observe(), ALL_HIGH);
      end
    end
    nAS = 1'b1;
    nDS = 1'b1;
    run_txn(1'b1, 2'b01, 0, 1'b1, 1'b1, 4, 2);
    for (int k = 1; k <= 6; k++) begin
      want = model(k, 1'b1, 0, 1'b1, ndsLog[k], 4, 1, 1'b1);
      checks++;
      if (obsLog[k] !== want) begin
        errors++; $display("FAIL after_reset edge %0d: got %b want %b", k, obsLog[k], want);
      end
    end
    $display("txn reset mid-wait: abandoned, fresh cycle runs normally");
  endtask

  task automatic test_back_to_back();
    outs_t want;
    run_txn(1'b1, 2'b01, 0, 1'b1, 1'b1, 3, 1);
    for (int k = 1; k <= 4; k++) begin
      want = model(k, 1'b1, 0, 1'b1, ndsLog[k], 3, 1, 1'b1);
      checks++;
      if (obsLog[k] !== want) begin
        errors++; $display("FAIL b2b_first edge %0d: got %b want %b", k, obsLog[k], want);
      end
    end
    // The controller is in DONE now. The next nAS is seen in DONE and ignored.
    addrSel = 3'd2;
    nAS     = 1'b0;
    @(negedge sysClk);
    checks++;
    if (nCS !== 4'hF) begin
      errors++; $display("FAIL b2b_done_blocks: got %b want 1111", nCS);
    end
    @(negedge sysClk);
    checks++;
    if (nCS !== 4'b1011) begin
      errors++; $display("FAIL b2b_accept: got %b want 1011", nCS);
    end
    repeat (4) @(negedge sysClk);
    checks++;
    if (nDsack !== 2'b10) begin
      errors++; $display("FAIL b2b_dsack: got %b want 10", nDsack);
    end
    nAS = 1'b1;
    repeat (2) @(negedge sysClk);
    $display("txn back-to-back: second cycle accepted one clock late");
  endtask

  task automatic test_random();
    outs_t      want;
    logic       a31, rnw, ext;
    logic [1:0] fc;
    int         sel, len, bad;
    for (int t = 0; t < 40; t++) begin
      a31 = ($urandom_range(0, 3) != 0);
      fc  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      rnw = 1'($urandom_range(0, 1));
      ext = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 24);
      run_txn(a31, fc, sel, rnw, ext, len, 2);
      bad = 0;
      for (int k = 1; k <= len + 2; k++) begin
        want = model(k, is_hit(a31, fc, sel), sel, rnw, ndsLog[k], len, 1, ext);
        checks++;
        if (obsLog[k] !== want) begin
          errors++; bad++;
          $display("FAIL random %0d edge %0d: got %b want %b", t, k, obsLog[k], want);
        end
      end
      $display("txn random %0d: a31=%0b fc=%0d sel=%0d rnw=%0b ext=%0b len=%0d bad=%0d",
               t, a31, fc, sel, rnw, ext, len, bad);
    end
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_write_zero_wait();
    test_unmapped_berr();
    test_extterm_no_berr();
    test_sync_port();
    test_timeout_tie();
    test_abort_wait();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
